// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine controller and its duration timer:
//   - controller state encoding (3-bit)
//   - clk_freq clock-rate select encoding
//   - minute values on which timeout pulses are generated
//   - small helper for pulse decoding
// -----------------------------------------------------------------------------
package wash_pkg;

    // Controller state encoding, shared with the controller FSM.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILLING  = 3'd1,
        ST_WASHING  = 3'd2,
        ST_RINSING  = 3'd3,
        ST_SPINNING = 3'd4
    } wash_state_e;

    // Clock-rate select: ticks per second = base << clk_freq.
    typedef enum logic [1:0] {
        FREQ_1MHZ = 2'b00,
        FREQ_2MHZ = 2'b01,
        FREQ_4MHZ = 2'b10,
        FREQ_8MHZ = 2'b11
    } clk_freq_e;

    // Minutes on which a timeout pulse is emitted.
    localparam logic [2:0] PULSE_MIN_1 = 3'd1;
    localparam logic [2:0] PULSE_MIN_2 = 3'd2;
    localparam logic [2:0] PULSE_MIN_5 = 3'd5;

    // Saturation value of the elapsed-minutes counter.
    localparam logic [2:0] MIN_SAT = 3'd7;

    // True when incrementing cur_min lands exactly on target.
    function automatic logic is_pulse_edge(input logic [2:0] cur_min,
                                           input logic [2:0] target);
        logic [2:0] nxt;
        nxt = cur_min + 3'd1;
        return (nxt == target);
    endfunction

endpackage

// File: rtl/wash_timer_sec_prescaler.sv
// -----------------------------------------------------------------------------
// sec_prescaler
// Divides clk down to a one-cycle sec_tick. The terminal count is derived from
// the live clk_freq, so a rate change takes effect on the next counting edge.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   clr       synchronous clear of the prescaler (restart / idle)
//   en        count enable (low while paused, cleared or idle)
//   clk_freq  rate select, ticks per second = SEC_TICKS_BASE << clk_freq
//   sec_tick  combinational, high on the counting edge where the prescaler wraps
// -----------------------------------------------------------------------------
module sec_prescaler
    import wash_pkg::*;
#(
    parameter int SEC_TICKS_BASE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] clk_freq,
    output logic       sec_tick
);

    // Wide enough for the 8 MHz setting; T-1 always fits.
    localparam int PW = $clog2(8 * SEC_TICKS_BASE);
    localparam logic [PW-1:0] BASE_P = PW'(SEC_TICKS_BASE);
    localparam logic [PW-1:0] ONE_P  = PW'(1);

    logic [PW-1:0] cnt_r;
    logic [PW-1:0] cnt_nxt_s;
    logic [PW-1:0] last_s;
    logic          term_s;

    // Terminal count and next prescaler value. The shift may wrap to zero at
    // the top rate (T == 2**PW); subtracting one modulo 2**PW still gives T-1.
    // ">=" rather than "==" makes a prescaler left above a newly lowered
    // terminal count wrap immediately instead of running on.
    always_comb begin
        last_s    = (BASE_P << clk_freq) - ONE_P;
        term_s    = (cnt_r >= last_s);
        sec_tick  = en && term_s;
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (en) begin
            if (term_s) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + ONE_P;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/wash_timer.sv
// -----------------------------------------------------------------------------
// wash_timer
// Measures time spent in the controller's current state and emits one-cycle
// timeout pulses after 1, 2 and 5 minutes. Timing restarts on every state
// change, is held at zero in IDLE and freezes while pause is high.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   clk_freq       rate select (00=1, 01=2, 10=4, 11=8 MHz)
//   current_state  controller state (wash_state_e encoding)
//   pause          freeze all counters while high
//   minutes_1      registered pulse, 1 minute elapsed
//   minutes_2      registered pulse, 2 minutes elapsed
//   minutes_5      registered pulse, 5 minutes elapsed
//   elapsed_min    whole minutes in current state, saturating at 7
// -----------------------------------------------------------------------------
module wash_timer
    import wash_pkg::*;
#(
    parameter int SEC_TICKS_BASE = 1_000_000,
    parameter int SEC_PER_MIN    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] clk_freq,
    input  logic [2:0] current_state,
    input  logic       pause,
    output logic       minutes_1,
    output logic       minutes_2,
    output logic       minutes_5,
    output logic [2:0] elapsed_min
);

    localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_MIN - 1);
    localparam logic [SW-1:0] SEC_ONE  = SW'(1);

    logic [2:0]    prev_state_r;
    logic [SW-1:0] sec_r;
    logic [SW-1:0] sec_nxt_s;
    logic [2:0]    min_nxt_s;
    logic          restart_s;
    logic          idle_s;
    logic          clr_s;
    logic          en_s;
    logic          sec_tick_s;
    logic          min_tick_s;
    logic          min_inc_s;
    logic          p1_nxt_s;
    logic          p2_nxt_s;
    logic          p5_nxt_s;

    // Restart beats pause beats count: a cleared cycle never enables counting,
    // so a terminal count coinciding with a restart or pause yields no pulse.
    always_comb begin
        restart_s = (current_state != prev_state_r);
        idle_s    = (current_state == ST_IDLE);
        clr_s     = restart_s || idle_s;
        en_s      = !clr_s && !pause;
    end

    sec_prescaler #(
        .SEC_TICKS_BASE (SEC_TICKS_BASE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .en       (en_s),
        .clk_freq (clk_freq),
        .sec_tick (sec_tick_s)
    );

    // Seconds/minutes next-state and pulse decode. sec_tick is already gated
    // by en, so min_inc implies a counting (non-cleared, non-paused) edge.
    always_comb begin
        min_tick_s = sec_tick_s && (sec_r == SEC_LAST);
        min_inc_s  = min_tick_s && (elapsed_min != MIN_SAT);

        sec_nxt_s = sec_r;
        if (clr_s) begin
            sec_nxt_s = '0;
        end else if (sec_tick_s) begin
            if (sec_r == SEC_LAST) begin
                sec_nxt_s = '0;
            end else begin
                sec_nxt_s = sec_r + SEC_ONE;
            end
        end else begin
            sec_nxt_s = sec_r;
        end

        min_nxt_s = elapsed_min;
        if (clr_s) begin
            min_nxt_s = 3'd0;
        end else if (min_inc_s) begin
            min_nxt_s = elapsed_min + 3'd1;
        end else begin
            min_nxt_s = elapsed_min;
        end

        p1_nxt_s = min_inc_s && is_pulse_edge(elapsed_min, PULSE_MIN_1);
        p2_nxt_s = min_inc_s && is_pulse_edge(elapsed_min, PULSE_MIN_2);
        p5_nxt_s = min_inc_s && is_pulse_edge(elapsed_min, PULSE_MIN_5);
    end

    // State history, counters and registered timeout pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_state_r <= 3'd0;
            sec_r        <= '0;
            elapsed_min  <= 3'd0;
            minutes_1    <= 1'b0;
            minutes_2    <= 1'b0;
            minutes_5    <= 1'b0;
        end else begin
            prev_state_r <= current_state;
            sec_r        <= sec_nxt_s;
            elapsed_min  <= min_nxt_s;
            minutes_1    <= p1_nxt_s;
            minutes_2    <= p2_nxt_s;
            minutes_5    <= p5_nxt_s;
        end
    end

endmodule

// File: doc/wash_timer.md
# wash_timer

Duration timer for the washing-machine controller. Watches the controller's `current_state` and counts elapsed time in the current state. Drives the `minutes_1`, `minutes_2` and `minutes_5` timeout pulses that the state FSM consumes to leave Filling_Water, Washing, Rinsing and Spinning. Time base comes from `clk_freq`, so one design runs at 1/2/4/8 MHz without resynthesis.

## Interface
Parameters:
- `SEC_TICKS_BASE`, default 1_000_000: clk cycles per second at `clk_freq`=2'b00 (1 MHz). Benches use small values.
- `SEC_PER_MIN`, default 60: seconds per minute. Benches use small values.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `clk_freq`  in  2  clock-rate select: 00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz.
- `current_state`  in  3  controller state: IDLE=0, FILLING=1, WASHING=2, RINSING=3, SPINNING=4.
- `pause`  in  1  freeze timing while high.
- `minutes_1`  out  1  one-cycle pulse when 1 minute has elapsed in the current state.
- `minutes_2`  out  1  one-cycle pulse when 2 minutes have elapsed.
- `minutes_5`  out  1  one-cycle pulse when 5 minutes have elapsed.
- `elapsed_min`  out  3  whole minutes elapsed in the current state; saturates at 7.

## Operation
- Ticks per second: T = `SEC_TICKS_BASE` << `clk_freq`. The terminal count is combinational from the live `clk_freq`.
- Counter chain:
  - Prescaler 0..T-1 produces a one-cycle `sec_tick` on wrap.
  - Seconds counter 0..`SEC_PER_MIN`-1 produces `min_tick` on wrap.
  - Minutes counter (`elapsed_min`) increments on `min_tick` and saturates at 7.
- Restart:
  - Register `prev_state` every cycle.
  - When `current_state` != `prev_state`, clear the prescaler, seconds and minutes counters on that edge.
  - Counting resumes on the next edge.
  - Rinsing->Washing (double wash) is a state change and restarts the timer.
- IDLE: all counters are held at 0 and no pulses are generated.
- Pause: while `pause`=1, all counters hold their value and no pulse fires. Resume continues from the held value.
- Pulses are registered. On the edge where the minutes counter goes k-1 -> k:
  - k=1: `minutes_1` is 1 for exactly the following cycle.
  - k=2: `minutes_2` is 1 for exactly the following cycle.
  - k=5: `minutes_5` is 1 for exactly the following cycle.
  - Other transitions produce no pulse.
  - At most one pulse output is high in any cycle.
- Priority: restart > pause > count.
  - A state change on the same edge as a terminal count clears the counters and produces no pulse.
  - Pause on the same edge as a terminal count holds the counters and produces no pulse.
- `clk_freq` changed mid-count: if the prescaler is already >= new T-1, treat it as terminal on the next counting edge and wrap to 0. Never overrun.
- Reset (asynchronous, any time): all counters, `prev_state` and `elapsed_min` go to 0. `minutes_1`, `minutes_2` and `minutes_5` go to 0.

## Timing
- Restart edge E0: counts start on E0+1.
- With no pause and constant `clk_freq`, `minutes_k` is high in the cycle following edge E0 + k·`SEC_PER_MIN`·T.
- `elapsed_min` updates on that same edge.
- Pauses extend this by exactly the number of paused cycles.
- Worst-case counter widths:
  - Prescaler: clog2(8·`SEC_TICKS_BASE`).
  - Seconds: clog2(`SEC_PER_MIN`).
  - Minutes: 3 bits.

## Structure
- Shared package `wash_pkg`:
  - State encodings IDLE/FILLING/WASHING/RINSING/SPINNING (3-bit type).
  - `clk_freq` encodings.
  - Pulse minute constants 1, 2, 5.
  - The controller FSM imports the same package.
- One sub-module, `sec_prescaler`:
  - Inputs: `clk`, `rst`, `clr`, `en`, `clk_freq`.
  - Output: `sec_tick`.
  - Parameterised by `SEC_TICKS_BASE`.
- Seconds/minutes counters and pulse logic live in `wash_timer`.

## Test plan
Bench parameters: `SEC_TICKS_BASE`=4, `SEC_PER_MIN`=3. At `clk_freq`=00, 1 minute = 12 cycles.
- Reset, state 0->1 at edge E0, `clk_freq`=00, no pause -> `minutes_1` high only in cycle E0+13, `minutes_2` at E0+25, `minutes_5` at E0+61. `elapsed_min` reaches 5; no further pulses through E0+200.
- Same run with `clk_freq`=11 (T=32) -> `minutes_2` at E0+193.
- State 1, `pause` high for 7 cycles starting E0+5 -> `minutes_1` at E0+20. No pulse while paused; counters unchanged across the pause.
- State change 2->3 at E0+50, then 3->2 on the exact edge `minutes_1` would fire -> no pulse. `elapsed_min`=0, and the next `minutes_1` is 13 cycles after the second change.
- State held at 0 for 100 cycles -> all pulses 0, `elapsed_min`=0.
- Async `rst` low mid-count at E0+30 for 2 cycles, then release with state 1 -> all outputs 0 immediately. Timer restarts from zero at the first post-reset state edge.
